// File: rtl/audio_mixer_pkg.sv
// Shared types and sizing helpers for the audio mixer.
// The optional AUDIO_MIXER_SAT_EN macro is consumed by audio_mixer_sat.
package audio_mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_IN_W   = 16;
    localparam int DEF_OUT_W  = 24;
    localparam int DEF_VOL_W  = 4;

    // Sum of NUM_CH signed sample*gain products can never exceed this width.
    function automatic int acc_width(input int in_w, input int vol_w, input int num_ch);
        return in_w + vol_w + $clog2(num_ch) + 1;
    endfunction

endpackage

// File: rtl/audio_mixer_sat.sv
// Reduces a wide signed mix result to IN_W bits.
// AUDIO_MIXER_SAT_EN defined: saturate and flag clipping; otherwise wrap, clip_o = 0.
module audio_mixer_sat #(
    parameter int IN_W  = 16,
    parameter int VAL_W = 21
) (
    input  logic signed [VAL_W-1:0] val_i,
    output logic        [IN_W-1:0]  res_o,
    output logic                    clip_o
);

`ifdef AUDIO_MIXER_SAT_EN
    logic fits;

    // The value fits when every bit above the IN_W sign bit matches the sign.
    assign fits = (val_i[VAL_W-1:IN_W-1] == {(VAL_W-IN_W+1){val_i[VAL_W-1]}});

    always_comb begin
        res_o  = val_i[IN_W-1:0];
        clip_o = 1'b0;
        if (!fits) begin
            clip_o = 1'b1;
            res_o  = val_i[VAL_W-1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign res_o     = val_i[IN_W-1:0];
    assign clip_o    = 1'b0;
    assign unused_hi = ^val_i[VAL_W-1:IN_W];
`endif

endmodule

// File: rtl/audio_mixer.sv
// Stereo mixer: snapshots NUM_CH sources, accumulates one channel per cycle,
// then reduces and publishes the result. AUDIO_MIXER_SAT_EN selects saturation.
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int VOL_W  = DEF_VOL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    next_sample,
    input  logic [NUM_CH*IN_W-1:0]  ch_left,
    input  logic [NUM_CH*IN_W-1:0]  ch_right,
    input  logic [NUM_CH*VOL_W-1:0] ch_volume,
    input  logic [NUM_CH-1:0]       ch_mute,
    output logic [OUT_W-1:0]        left_data,
    output logic [OUT_W-1:0]        right_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    clip_l,
    output logic                    clip_r
);

    localparam int ACC_W = acc_width(IN_W, VOL_W, NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [NUM_CH*IN_W-1:0]    snap_l_q, snap_l_d, snap_r_q, snap_r_d;
    logic [NUM_CH*VOL_W-1:0]   snap_v_q, snap_v_d;
    logic [NUM_CH-1:0]         snap_m_q, snap_m_d;
    logic [OUT_W-1:0]          left_q, left_d, right_q, right_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      clip_l_q, clip_l_d, clip_r_q, clip_r_d;

    logic signed [IN_W-1:0]    smp_l, smp_r;
    logic [VOL_W-1:0]          vol;
    logic                      mute;
    logic signed [IN_W+VOL_W:0] prod_l, prod_r;
    logic signed [ACC_W-1:0]   shift_l, shift_r;
    logic [IN_W-1:0]           red_l, red_r;
    logic                      sat_clip_l, sat_clip_r;
    logic [OUT_W-1:0]          ext_l, ext_r;

    assign smp_l = snap_l_q[int'(idx_q)*IN_W +: IN_W];
    assign smp_r = snap_r_q[int'(idx_q)*IN_W +: IN_W];
    assign vol   = snap_v_q[int'(idx_q)*VOL_W +: VOL_W];
    assign mute  = snap_m_q[idx_q];

    // Volume is unsigned, so widen it with a zero MSB before the signed multiply.
    always_comb begin
        prod_l = smp_l * $signed({1'b0, vol});
        prod_r = smp_r * $signed({1'b0, vol});
        if (mute) begin
            prod_l = '0;
            prod_r = '0;
        end
    end

    // Gain 2^(VOL_W-1) is unity, so drop VOL_W-1 fractional bits.
    assign shift_l = acc_l_q >>> (VOL_W-1);
    assign shift_r = acc_r_q >>> (VOL_W-1);

    audio_mixer_sat #(.IN_W(IN_W), .VAL_W(ACC_W)) u_sat_l (
        .val_i  (shift_l),
        .res_o  (red_l),
        .clip_o (sat_clip_l)
    );

    audio_mixer_sat #(.IN_W(IN_W), .VAL_W(ACC_W)) u_sat_r (
        .val_i  (shift_r),
        .res_o  (red_r),
        .clip_o (sat_clip_r)
    );

    always_comb begin
        ext_l = '0;
        ext_r = '0;
        ext_l[OUT_W-1 -: IN_W] = red_l;
        ext_r[OUT_W-1 -: IN_W] = red_r;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        snap_l_d    = snap_l_q;
        snap_r_d    = snap_r_q;
        snap_v_d    = snap_v_q;
        snap_m_d    = snap_m_q;
        left_d      = left_q;
        right_d     = right_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        clip_l_d    = clip_l_q;
        clip_r_d    = clip_r_q;

        if (overrun_clr) begin
            overrun_d = 1'b0;
            clip_l_d  = 1'b0;
            clip_r_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (next_sample) begin
                    snap_l_d = ch_left;
                    snap_r_d = ch_right;
                    snap_v_d = ch_volume;
                    snap_m_d = ch_mute;
                    acc_l_d  = '0;
                    acc_r_d  = '0;
                    idx_d    = '0;
                    state_d  = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_l_d = acc_l_q + ACC_W'(prod_l);
                acc_r_d = acc_r_q + ACC_W'(prod_r);
                if (idx_q == IDX_W'(NUM_CH-1)) begin
                    state_d = ST_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_OUT: begin
                left_d      = ext_l;
                right_d     = ext_r;
                out_valid_d = 1'b1;
                if (sat_clip_l) clip_l_d = 1'b1;
                if (sat_clip_r) clip_r_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A strobe during a mix is dropped but remembered; it wins over a clear.
        if (next_sample && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            snap_l_q    <= '0;
            snap_r_q    <= '0;
            snap_v_q    <= '0;
            snap_m_q    <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            snap_l_q    <= snap_l_d;
            snap_r_q    <= snap_r_d;
            snap_v_q    <= snap_v_d;
            snap_m_q    <= snap_m_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            clip_l_q    <= clip_l_d;
            clip_r_q    <= clip_r_d;
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;
    assign clip_l     = clip_l_q;
    assign clip_r     = clip_r_q;

endmodule
